// File: rtl/hls_multich_ctrl_package.sv
// Shared types and constants for the multi-channel HLS control FSM and its
// per-channel trackers.
package hls_multich_ctrl_package;

    typedef enum logic [2:0] {
        IDLE,
        START,
        COMPUTE,
        UPDATEIDX,
        TERMINATE
    } state_fsm_t;

    localparam int DEF_CNT_LEN = 1605632;
    localparam int DEF_CNT_W   = $clog2(DEF_CNT_LEN) + 1;
    localparam int DEF_ITER_W  = 16;
    localparam int DEF_ADDR_W  = 32;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_CNT_W-1:0]  len;
        logic [DEF_ADDR_W-1:0] stride;
    } ch_cfg_t;

    typedef struct packed {
        logic accepted;
        logic done;
    } ch_status_t;

endpackage

// File: rtl/hls_ch_tracker.sv
// One streamer channel: latched length/stride, address accumulator, request
// generation and sticky accepted/done bits. A zero length disables the channel.
module hls_ch_tracker
    import hls_multich_ctrl_package::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic              clear_i,
    input  logic              in_start_i,
    input  logic              in_run_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic              ready_i,
    input  logic              done_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [CNT_W-1:0]  len_o,
    output logic              accept_now_o,
    output logic              done_now_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [CNT_W-1:0]  len_q, len_d;
    ch_status_t        status_q, status_d;
    logic              enable;

    assign enable = (len_q != '0);
    assign req_o  = in_start_i & enable & ~status_q.accepted;
    assign addr_o = addr_q;
    assign len_o  = len_q;

    // The "_now" views include this cycle's handshake so the FSM can move on
    // in the same cycle as the last accept / done.
    assign accept_now_o = ~enable | status_q.accepted | (req_o & ready_i);
    assign done_now_o   = ~enable | status_q.done | (status_q.accepted & done_i);

    always_comb begin
        addr_d   = addr_q;
        len_d    = len_q;
        stride_d = stride_q;
        status_d = status_q;
        if (clear_i) begin
            status_d = '0;
        end else if (load_i) begin
            addr_d   = addr_i;
            len_d    = len_i;
            stride_d = stride_i;
            status_d = '0;
        end else if (advance_i) begin
            addr_d   = addr_q + stride_q;
            status_d = '0;
        end else begin
            if (req_o & ready_i) begin
                status_d.accepted = 1'b1;
            end
            if (in_run_i & status_q.accepted & done_i) begin
                status_d.done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            len_q    <= '0;
            stride_q <= '0;
            status_q <= '0;
        end else begin
            addr_q   <= addr_d;
            len_q    <= len_d;
            stride_q <= stride_d;
            status_q <= status_d;
        end
    end

endmodule

// File: rtl/hls_multich_ctrl_fsm.sv
// Control FSM sequencing N_IN sources and N_OUT sinks through nb_iter
// iterations of request / compute / address-advance.
module hls_multich_ctrl_fsm
    import hls_multich_ctrl_package::*;
#(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ITER_W = DEF_ITER_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    trigger_i,
    input  logic [ITER_W-1:0]       nb_iter_i,
    input  logic [N_IN*ADDR_W-1:0]  in_addr_i,
    input  logic [N_IN*CNT_W-1:0]   in_len_i,
    input  logic [N_IN*ADDR_W-1:0]  in_stride_i,
    input  logic [N_OUT*ADDR_W-1:0] out_addr_i,
    input  logic [N_OUT*CNT_W-1:0]  out_len_i,
    input  logic [N_OUT*ADDR_W-1:0] out_stride_i,
    output logic [N_IN-1:0]         src_req_o,
    output logic [N_IN*ADDR_W-1:0]  src_addr_o,
    output logic [N_IN*CNT_W-1:0]   src_len_o,
    input  logic [N_IN-1:0]         src_ready_i,
    input  logic [N_IN-1:0]         src_done_i,
    output logic [N_OUT-1:0]        snk_req_o,
    output logic [N_OUT*ADDR_W-1:0] snk_addr_o,
    output logic [N_OUT*CNT_W-1:0]  snk_len_o,
    input  logic [N_OUT-1:0]        snk_ready_i,
    input  logic [N_OUT-1:0]        snk_done_i,
    output logic                    eng_start_o,
    output logic                    eng_clear_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [ITER_W-1:0]       iter_o
);

    localparam int N_CH = N_IN + N_OUT;

    state_fsm_t        state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d, nb_iter_q, nb_iter_d, iter_inc;
    logic              eng_start_q, eng_start_d;
    logic              load, advance, in_start, in_run;

    logic [N_CH-1:0]        ch_req, ch_ready, ch_done, accept_now, done_now;
    logic [N_CH*ADDR_W-1:0] ch_addr_in, ch_stride_in, ch_addr_out;
    logic [N_CH*CNT_W-1:0]  ch_len_in, ch_len_out;

    // Sources occupy the low channel indices, sinks the high ones.
    assign ch_addr_in   = {out_addr_i, in_addr_i};
    assign ch_stride_in = {out_stride_i, in_stride_i};
    assign ch_len_in    = {out_len_i, in_len_i};
    assign ch_ready     = {snk_ready_i, src_ready_i};
    assign ch_done      = {snk_done_i, src_done_i};

    assign src_req_o  = ch_req[N_IN-1:0];
    assign snk_req_o  = ch_req[N_CH-1:N_IN];
    assign src_addr_o = ch_addr_out[N_IN*ADDR_W-1:0];
    assign snk_addr_o = ch_addr_out[N_CH*ADDR_W-1:N_IN*ADDR_W];
    assign src_len_o  = ch_len_out[N_IN*CNT_W-1:0];
    assign snk_len_o  = ch_len_out[N_CH*CNT_W-1:N_IN*CNT_W];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        hls_ch_tracker #(
            .CNT_W (CNT_W),
            .ADDR_W(ADDR_W)
        ) u_trk (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .load_i      (load),
            .advance_i   (advance),
            .clear_i     (clear_i),
            .in_start_i  (in_start),
            .in_run_i    (in_run),
            .addr_i      (ch_addr_in[c*ADDR_W +: ADDR_W]),
            .len_i       (ch_len_in[c*CNT_W +: CNT_W]),
            .stride_i    (ch_stride_in[c*ADDR_W +: ADDR_W]),
            .ready_i     (ch_ready[c]),
            .done_i      (ch_done[c]),
            .req_o       (ch_req[c]),
            .addr_o      (ch_addr_out[c*ADDR_W +: ADDR_W]),
            .len_o       (ch_len_out[c*CNT_W +: CNT_W]),
            .accept_now_o(accept_now[c]),
            .done_now_o  (done_now[c])
        );
    end

    assign in_start    = (state_q == START);
    assign in_run      = (state_q == START) || (state_q == COMPUTE);
    assign iter_inc    = iter_q + 1'b1;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == TERMINATE) && !clear_i;
    assign eng_start_o = eng_start_q;
    assign iter_o      = iter_q;

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        nb_iter_d   = nb_iter_q;
        eng_start_d = 1'b0;
        eng_clear_o = 1'b0;
        load        = 1'b0;
        advance     = 1'b0;
        if (clear_i) begin
            state_d     = IDLE;
            iter_d      = '0;
            eng_clear_o = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trigger_i) begin
                        load        = 1'b1;
                        eng_clear_o = 1'b1;
                        iter_d      = '0;
                        nb_iter_d   = nb_iter_i;
                        state_d     = (nb_iter_i == '0) ? TERMINATE : START;
                    end
                end
                START: begin
                    if (&accept_now) begin
                        state_d     = COMPUTE;
                        eng_start_d = 1'b1;
                    end
                end
                COMPUTE: begin
                    if (&done_now) begin
                        state_d = UPDATEIDX;
                    end
                end
                UPDATEIDX: begin
                    advance = 1'b1;
                    iter_d  = iter_inc;
                    state_d = (iter_inc == nb_iter_q) ? TERMINATE : START;
                end
                TERMINATE: state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            nb_iter_q   <= '0;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            nb_iter_q   <= nb_iter_d;
            eng_start_q <= eng_start_d;
        end
    end

endmodule

// File: tb/tb_hls_multich_ctrl_fsm.sv
// Bench for hls_multich_ctrl_fsm with two sources and one sink; channel
// responders answer req/ready/done with per-channel delays.
module tb_hls_multich_ctrl_fsm;

    localparam int N_IN   = 2;
    localparam int N_OUT  = 1;
    localparam int NCH    = 3;
    localparam int CNT_W  = 22;
    localparam int ADDR_W = 32;
    localparam int ITER_W = 16;

    typedef struct {
        int                             nbIter;
        logic [NCH-1:0][CNT_W-1:0]      len;
        logic [NCH-1:0][ADDR_W-1:0]     base;
        logic [NCH-1:0][ADDR_W-1:0]     stride;
        logic [NCH-1:0][7:0]            rdly;
        logic [NCH-1:0][7:0]            ddly;
        int                             expStarts;
        int                             expCycles;
        logic [31:0]                    expLastAddr0;
        bit                             isTable;
    } jobVec_t;

    logic clk = 1'b0;
    logic rstN, clear, trigger;
    jobVec_t drv, cur;

    logic [N_IN-1:0]         srcReq, srcReady, srcDone;
    logic [N_IN*ADDR_W-1:0]  srcAddr;
    logic [N_IN*CNT_W-1:0]   srcLen;
    logic [N_OUT-1:0]        snkReq, snkReady, snkDone;
    logic [N_OUT*ADDR_W-1:0] snkAddr;
    logic [N_OUT*CNT_W-1:0]  snkLen;
    logic engStart, engClear, busy, doneO;
    logic [ITER_W-1:0] iter;

    logic [NCH-1:0] chReq, chReady, chDone;
    logic [31:0]      chAddr[NCH];
    logic [CNT_W-1:0] chLen[NCH];

    always #5 clk = ~clk;

    hls_multich_ctrl_fsm #(
        .N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .ITER_W(ITER_W)
    ) dut (
        .clk_i(clk), .rst_ni(rstN), .clear_i(clear), .trigger_i(trigger),
        .nb_iter_i(16'(drv.nbIter)),
        .in_addr_i({drv.base[1], drv.base[0]}),
        .in_len_i({drv.len[1], drv.len[0]}),
        .in_stride_i({drv.stride[1], drv.stride[0]}),
        .out_addr_i(drv.base[2]), .out_len_i(drv.len[2]), .out_stride_i(drv.stride[2]),
        .src_req_o(srcReq), .src_addr_o(srcAddr), .src_len_o(srcLen),
        .src_ready_i(srcReady), .src_done_i(srcDone),
        .snk_req_o(snkReq), .snk_addr_o(snkAddr), .snk_len_o(snkLen),
        .snk_ready_i(snkReady), .snk_done_i(snkDone),
        .eng_start_o(engStart), .eng_clear_o(engClear), .busy_o(busy),
        .done_o(doneO), .iter_o(iter)
    );

    assign chReq    = {snkReq, srcReq};
    assign srcReady = chReady[1:0];
    assign snkReady = chReady[2];
    assign srcDone  = chDone[1:0];
    assign snkDone  = chDone[2];

    always_comb begin
        chAddr[0] = srcAddr[31:0];
        chAddr[1] = srcAddr[63:32];
        chAddr[2] = snkAddr;
        chLen[0]  = srcLen[CNT_W-1:0];
        chLen[1]  = srcLen[2*CNT_W-1:CNT_W];
        chLen[2]  = snkLen;
    end

    int vecCount = 0;
    int missCount = 0;
    int cyc = 0;
    int jobId = 0;
    int tTrig = 0;

    int engStarts, doneCnt, doneCyc;
    int reqCyc[NCH];
    int timer[NCH];
    int rcnt[NCH];
    bit addrBad, busyBad;
    logic [31:0] firstAddr[NCH];
    logic [31:0] accQ[NCH][$];
    int iterQ[$];

    task automatic check(input string name, input longint act, input longint exp);
        vecCount++;
        if (act != exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Channel responders and observation recorder, all at the falling edge.
    initial begin : monitor
        int seenJob;
        seenJob = 0;
        chReady = '0;
        chDone  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (seenJob != jobId) begin
                seenJob = jobId;
                engStarts = 0; doneCnt = 0; doneCyc = 0;
                addrBad = 0; busyBad = 0;
                iterQ.delete();
                for (int c = 0; c < NCH; c++) begin
                    reqCyc[c] = 0; timer[c] = 0; rcnt[c] = 0;
                    accQ[c].delete();
                end
            end
            if (!rstN) begin
                chReady = '0;
                chDone  = '0;
                for (int c = 0; c < NCH; c++) begin
                    timer[c] = 0; rcnt[c] = 0;
                end
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    chDone[c] = 1'b0;
                    if (timer[c] > 0) begin
                        timer[c]--;
                        if (timer[c] == 0) chDone[c] = 1'b1;
                    end
                    if (chReq[c]) begin
                        if (rcnt[c] == 0) firstAddr[c] = chAddr[c];
                        else if (chAddr[c] != firstAddr[c]) addrBad = 1;
                        if (chLen[c] != cur.len[c]) addrBad = 1;
                        chReady[c] = (rcnt[c] >= int'(cur.rdly[c]));
                        rcnt[c]++;
                        reqCyc[c]++;
                        if (chReady[c]) accQ[c].push_back(chAddr[c]);
                    end else begin
                        chReady[c] = 1'b0;
                        rcnt[c] = 0;
                    end
                end
                if (engStart) begin
                    engStarts++;
                    iterQ.push_back(int'(iter));
                    for (int c = 0; c < NCH; c++)
                        if (cur.len[c] != 0) timer[c] = int'(cur.ddly[c]);
                end
                if (doneO) begin
                    doneCnt++;
                    doneCyc = cyc;
                    if (!busy) busyBad = 1;
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    function automatic jobVec_t mk(input int nb, input logic [NCH*CNT_W-1:0] len,
                                   input logic [NCH*32-1:0] base, input logic [NCH*32-1:0] stride,
                                   input logic [23:0] rdly, input logic [23:0] ddly,
                                   input int es, input int ec, input logic [31:0] la, input bit tbl);
        jobVec_t v;
        v.nbIter = nb; v.len = len; v.base = base; v.stride = stride;
        v.rdly = rdly; v.ddly = ddly;
        v.expStarts = es; v.expCycles = ec; v.expLastAddr0 = la; v.isTable = tbl;
        return v;
    endfunction

    // Each iteration: slowest accept, engine start one cycle later, slowest
    // done, then one cycle into UPDATEIDX and one more to START/TERMINATE.
    function automatic int modelLatency(input jobVec_t v);
        int maxd = 0, maxdd = 0;
        for (int c = 0; c < NCH; c++) begin
            if (v.len[c] != 0) begin
                if (int'(v.rdly[c]) > maxd)  maxd  = int'(v.rdly[c]);
                if (int'(v.ddly[c]) > maxdd) maxdd = int'(v.ddly[c]);
            end
        end
        return 1 + v.nbIter * (maxd + maxdd + 3);
    endfunction

    task automatic fireTrigger(input jobVec_t v);
        @(posedge clk); #1;
        jobId++;
        cur = v;
        drv = v;
        trigger = 1'b1;
        tTrig = cyc + 1;
        #1 check("eng_clear on trigger", longint'(engClear), 1);
        @(posedge clk); #1;
        trigger = 1'b0;
        drv.nbIter = $urandom_range(1, 60);
        drv.base   = {$urandom, $urandom, $urandom};
        drv.stride = {$urandom, $urandom, $urandom};
        for (int c = 0; c < NCH; c++) drv.len[c] = CNT_W'($urandom);
    endtask

    task automatic applyStimulus(input jobVec_t v);
        int budget;
        budget = modelLatency(v) + 50;
        fireTrigger(v);
        for (int i = 0; i < budget && doneCnt == 0; i++) @(posedge clk);
        check("job completes within budget", longint'(doneCnt > 0), 1);
        @(negedge clk); #1;
        check("busy low after done", longint'(busy), 0);
    endtask

    task automatic checkOutput(input jobVec_t v);
        int nb;
        nb = v.nbIter;
        check("done_o count", doneCnt, 1);
        check("trigger->done latency", doneCyc - tTrig, modelLatency(v));
        check("eng_start count", engStarts, nb);
        check("busy at done", longint'(busyBad), 0);
        check("addr/len stable under req", longint'(addrBad), 0);
        for (int c = 0; c < NCH; c++) begin
            bit en;
            en = (v.len[c] != 0);
            check($sformatf("req cycles ch%0d", c), reqCyc[c], en ? nb * (int'(v.rdly[c]) + 1) : 0);
            check($sformatf("accepts ch%0d", c), accQ[c].size(), en ? nb : 0);
            for (int k = 0; k < accQ[c].size() && k < nb; k++) begin
                logic [31:0] ea;
                ea = v.base[c] + 32'(k) * v.stride[c];
                check($sformatf("addr ch%0d it%0d", c, k), accQ[c][k], ea);
            end
        end
        for (int k = 0; k < iterQ.size(); k++)
            check($sformatf("iter_o at start %0d", k), iterQ[k], k);
        if (v.isTable) begin
            check("table eng_start count", engStarts, v.expStarts);
            check("table latency", doneCyc - tTrig, v.expCycles);
            if (nb > 0 && accQ[0].size() == nb)
                check("table last src0 addr", accQ[0][nb-1], v.expLastAddr0);
        end
    endtask

    jobVec_t vecs[7];
    jobVec_t base0;

    initial begin : main
        rstN = 1'b0; clear = 1'b0; trigger = 1'b0;
        drv = mk(0, '0, '0, '0, '0, '0, 0, 0, 0, 0);
        cur = drv;
        #3;
        check("reset busy_o", longint'(busy), 0);
        check("reset done_o", longint'(doneO), 0);
        check("reset req", longint'({snkReq, srcReq}), 0);
        check("reset eng_start_o", longint'(engStart), 0);
        check("reset iter_o", longint'(iter), 0);
        check("reset src_addr_o", longint'(srcAddr), 0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;

        // Channel order in every packed field: {sink, src1, src0}.
        vecs[0] = mk(3, {22'd16, 22'd16, 22'd16}, {32'h3000, 32'h2000, 32'h1000},
                     {32'h100, 32'h40, 32'h40}, {8'd0, 8'd0, 8'd0}, {8'd10, 8'd10, 8'd10},
                     3, 40, 32'h1080, 1);
        vecs[1] = mk(2, {22'd16, 22'd16, 22'd16}, {32'h3000, 32'h2000, 32'h1000},
                     {32'h100, 32'h40, 32'h40}, {8'd0, 8'd5, 8'd0}, {8'd10, 8'd10, 8'd10},
                     2, 37, 32'h1040, 1);
        vecs[2] = mk(2, {22'd16, 22'd16, 22'd16}, {32'h3000, 32'h2000, 32'h1000},
                     {32'h100, 32'h40, 32'h40}, {8'd0, 8'd0, 8'd0}, {8'd3, 8'd8, 8'd8},
                     2, 23, 32'h1040, 1);
        vecs[3] = mk(2, {22'd16, 22'd16, 22'd16}, {32'h3000, 32'h2000, 32'h1000},
                     {32'h100, 32'h40, 32'h40}, {8'd0, 8'd0, 8'd0}, {8'd5, 8'd5, 8'd5},
                     2, 17, 32'h1040, 1);
        vecs[4] = mk(2, {22'd16, 22'd0, 22'd16}, {32'h3000, 32'h2000, 32'h1000},
                     {32'h100, 32'h40, 32'h40}, {8'd1, 8'd3, 8'd0}, {8'd6, 8'd9, 8'd4},
                     2, 21, 32'h1040, 1);
        vecs[5] = mk(0, {22'd16, 22'd16, 22'd16}, {32'h3000, 32'h2000, 32'h1000},
                     {32'h100, 32'h40, 32'h40}, {8'd0, 8'd0, 8'd0}, {8'd4, 8'd4, 8'd4},
                     0, 1, 32'h0, 1);
        vecs[6] = mk(2, {22'd8, 22'd8, 22'd8}, {32'h3000, 32'h2000, 32'hFFFF_FFC0},
                     {32'h20, 32'h10, 32'h40}, {8'd0, 8'd0, 8'd0}, {8'd2, 8'd2, 8'd2},
                     2, 11, 32'h0, 1);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        for (int i = 0; i < 8; i++) begin
            jobVec_t r;
            r = mk($urandom_range(1, 4), '0, {$urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom}, '0, '0, 0, 0, 0, 0);
            for (int c = 0; c < NCH; c++) begin
                r.len[c]  = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(1, 4095));
                r.rdly[c] = 8'($urandom_range(0, 4));
                r.ddly[c] = 8'($urandom_range(1, 10));
            end
            applyStimulus(r);
            checkOutput(r);
        end

        // Abort during COMPUTE of iteration 1, then restart from the base.
        base0 = vecs[0];
        fireTrigger(base0);
        for (int i = 0; i < 200 && engStarts < 2; i++) @(posedge clk);
        check("reached iteration 1", engStarts, 2);
        @(posedge clk); #1;
        clear = 1'b1;
        #1 check("eng_clear on abort", longint'(engClear), 1);
        @(posedge clk); #1;
        clear = 1'b0;
        check("busy after abort", longint'(busy), 0);
        check("req after abort", longint'(chReq), 0);
        check("iter after abort", longint'(iter), 0);
        repeat (20) @(posedge clk);
        check("no done_o after abort", doneCnt, 0);
        base0.nbIter = 1; base0.isTable = 0;
        applyStimulus(base0);
        checkOutput(base0);

        // Clear and trigger together: clear wins.
        @(posedge clk); #1;
        jobId++;
        cur = vecs[0]; drv = vecs[0];
        trigger = 1'b1; clear = 1'b1;
        #1 check("eng_clear on clear+trigger", longint'(engClear), 1);
        @(posedge clk); #1;
        trigger = 1'b0; clear = 1'b0;
        check("busy after clear+trigger", longint'(busy), 0);
        repeat (5) @(posedge clk);
        check("no start after clear+trigger", engStarts, 0);

        // Asynchronous reset in the middle of a job.
        fireTrigger(vecs[0]);
        repeat (8) @(posedge clk);
        #1 rstN = 1'b0;
        #1;
        check("busy in mid-job reset", longint'(busy), 0);
        check("req in mid-job reset", longint'(chReq), 0);
        check("iter in mid-job reset", longint'(iter), 0);
        @(posedge clk); #1 rstN = 1'b1;
        repeat (30) @(posedge clk);
        check("no done_o after reset", doneCnt, 0);
        applyStimulus(vecs[6]);
        checkOutput(vecs[6]);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
